knight_tour_solver: RTL and testbench

- Parametrised successor of the 5x5 tour engine: finds a knight's tour on a BOARD_DIM x BOARD_DIM board by depth-first backtracking.
- Sits between the start-position command decoder and TourCmd; TourCmd reads the solved moves out by index.
- Adds three things the 5x5 engine lacks: a configurable board size, an explicit fail result when no tour exists, and a true one-cycle done pulse.

---
 rtl/tour_pkg.sv | 58 +++++
 rtl/tour_move_gen.sv | 40 ++++
 rtl/knight_tour_solver.sv | 200 ++++++++++++++++++++
 tb/tb_knight_tour_solver.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tour_pkg.sv
// rtl/tour_pkg.sv - shared move encoding, FSM states and board geometry helpers
// for the knight's tour solver.
package tour_pkg;

  localparam logic [7:0] MV_B0 = 8'h01;  // (-1,+2)
  localparam logic [7:0] MV_B1 = 8'h02;  // (+1,+2)
  localparam logic [7:0] MV_B2 = 8'h04;  // (-2,+1)
  localparam logic [7:0] MV_B3 = 8'h08;  // (-2,-1)
  localparam logic [7:0] MV_B4 = 8'h10;  // (-1,-2)
  localparam logic [7:0] MV_B5 = 8'h20;  // (+1,-2)
  localparam logic [7:0] MV_B6 = 8'h40;  // (+2,-1)
  localparam logic [7:0] MV_B7 = 8'h80;  // (+2,+1)

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_POSS,
    ST_MOVE,
    ST_BACKUP,
    ST_DONE,
    ST_FAIL
  } tour_state_t;

  function automatic logic signed [2:0] off_x(input logic [7:0] mv);
    case (mv)
      MV_B0, MV_B4: off_x = -3'sd1;
      MV_B1, MV_B5: off_x = 3'sd1;
      MV_B2, MV_B3: off_x = -3'sd2;
      MV_B6, MV_B7: off_x = 3'sd2;
      default:      off_x = 3'sd0;
    endcase
  endfunction

  function automatic logic signed [2:0] off_y(input logic [7:0] mv);
    case (mv)
      MV_B0, MV_B1: off_y = 3'sd2;
      MV_B2, MV_B7: off_y = 3'sd1;
      MV_B3, MV_B6: off_y = -3'sd1;
      MV_B4, MV_B5: off_y = -3'sd2;
      default:      off_y = 3'sd0;
    endcase
  endfunction

  // Bit i set when move i from (x,y) lands on a dim x dim board.
  function automatic logic [7:0] in_bounds_mask(input int x, input int y, input int dim);
    logic [7:0] m;
    int tx;
    int ty;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      tx = x + int'(off_x(8'h01 << i));
      ty = y + int'(off_y(8'h01 << i));
      m[i] = (tx >= 0) && (tx < dim) && (ty >= 0) && (ty < dim);
    end
    return m;
  endfunction

endpackage

// File: rtl/tour_move_gen.sv
// rtl/tour_move_gen.sv - combinational target square and legality for one
// candidate knight move.
module tour_move_gen
  import tour_pkg::*;
#(
  parameter int BOARD_DIM = 5,
  parameter int CW        = $clog2(BOARD_DIM)
) (
  input  logic [CW-1:0]                  xx,
  input  logic [CW-1:0]                  yy,
  input  logic [7:0]                     try_mv,
  input  logic [BOARD_DIM*BOARD_DIM-1:0] board,
  output logic                           legal,
  output logic [CW-1:0]                  next_x,
  output logic [CW-1:0]                  next_y
);

  localparam int AW = $clog2(BOARD_DIM*BOARD_DIM);

  logic signed [CW:0] tx;
  logic signed [CW:0] ty;
  logic               in_range;
  logic [AW-1:0]      idx;

  // An overflow past the top edge wraps to a negative value, so the sign bit
  // alone rejects both edges' low side and the wrapped high side.
  always_comb begin
    tx       = $signed({1'b0, xx}) + (CW+1)'(off_x(try_mv));
    ty       = $signed({1'b0, yy}) + (CW+1)'(off_y(try_mv));
    in_range = !tx[CW] && !ty[CW] &&
               ({1'b0, tx[CW-1:0]} < (CW+1)'(BOARD_DIM)) &&
               ({1'b0, ty[CW-1:0]} < (CW+1)'(BOARD_DIM));
    idx      = AW'(int'(ty[CW-1:0]) * BOARD_DIM + int'(tx[CW-1:0]));
    legal    = 1'b0;
    if (in_range) legal = (|try_mv) & ~board[idx];
    next_x   = tx[CW-1:0];
    next_y   = ty[CW-1:0];
  end

endmodule

// File: rtl/knight_tour_solver.sv
// rtl/knight_tour_solver.sv - depth-first backtracking knight's tour engine on a
// BOARD_DIM square board; TOUR_TIMEOUT_EN adds a per-solve cycle budget and timed_out.
module knight_tour_solver
  import tour_pkg::*;
#(
  parameter int BOARD_DIM = 5,
  parameter int CW        = $clog2(BOARD_DIM),
  parameter int NMOVES    = BOARD_DIM*BOARD_DIM-1,
  parameter int IW        = $clog2(NMOVES)
`ifdef TOUR_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 2**24
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] x_start,
  input  logic [CW-1:0] y_start,
  input  logic          go,
  output logic          busy,
  output logic          done,
  output logic          fail,
`ifdef TOUR_TIMEOUT_EN
  output logic          timed_out,
`endif
  input  logic [IW-1:0] indx,
  output logic [7:0]    move
);

  localparam int NSQ = BOARD_DIM*BOARD_DIM;
  localparam int AW  = $clog2(NSQ);
  localparam int MW  = IW + 1;

  tour_state_t   state, state_n;
  logic          go_ff1, go_ff2;
  logic [CW-1:0] xx, yy;
  logic [7:0]    try_mv;
  logic [MW-1:0] move_count;
  logic [NSQ-1:0] board;
  logic [7:0]    moves_taken [NMOVES];
  logic [7:0]    poss_moves  [NMOVES];

  logic          gen_legal;
  logic [CW-1:0] gen_x, gen_y;
  logic          cand_legal, start_ok, last_move;
  logic [IW-1:0] mc_idx, mc_prev;
  logic [7:0]    prev_mv;

  function automatic logic [AW-1:0] sq(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return AW'(int'(y) * BOARD_DIM + int'(x));
  endfunction

  tour_move_gen #(.BOARD_DIM(BOARD_DIM), .CW(CW)) u_move_gen (
    .xx    (xx),
    .yy    (yy),
    .try_mv(try_mv),
    .board (board),
    .legal (gen_legal),
    .next_x(gen_x),
    .next_y(gen_y)
  );

  assign mc_idx     = move_count[IW-1:0];
  assign mc_prev    = IW'(move_count - 1'b1);
  assign prev_mv    = moves_taken[mc_prev];
  assign cand_legal = gen_legal && |(try_mv & poss_moves[mc_idx]);
  assign last_move  = (move_count == MW'(NMOVES-1));
  assign start_ok   = ({1'b0, x_start} < (CW+1)'(BOARD_DIM)) &&
                      ({1'b0, y_start} < (CW+1)'(BOARD_DIM));
  assign move       = ({1'b0, indx} < (IW+1)'(NMOVES)) ? moves_taken[indx] : 8'h00;

`ifdef TOUR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC+1);
  logic [TW-1:0] cyc_cnt;
  logic          timeout_hit;

  // INIT is busy cycle one with the counter at zero, so the last allowed busy
  // cycle sees TIMEOUT_CYC-2.
  assign timeout_hit = busy && (state != ST_INIT) && (cyc_cnt == TW'(TIMEOUT_CYC-2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt   <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state == ST_INIT) cyc_cnt <= '0;
      else if (busy) cyc_cnt <= cyc_cnt + 1'b1;
      if (state == ST_IDLE && go_ff2) timed_out <= 1'b0;
      else if (timeout_hit) timed_out <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    fail    = 1'b0;
    case (state)
      ST_IDLE: if (go_ff2) state_n = ST_INIT;
      ST_INIT: begin
        busy    = 1'b1;
        state_n = start_ok ? ST_POSS : ST_FAIL;
      end
      ST_POSS: begin
        busy    = 1'b1;
        state_n = ST_MOVE;
      end
      ST_MOVE: begin
        busy = 1'b1;
        if (cand_legal) state_n = last_move ? ST_DONE : ST_POSS;
        else if (try_mv == MV_B7) state_n = ST_BACKUP;
      end
      ST_BACKUP: begin
        busy = 1'b1;
        if (move_count == '0) state_n = ST_FAIL;
        else if ((prev_mv << 1) == 8'h00) state_n = ST_BACKUP;
        else state_n = ST_MOVE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      ST_FAIL: begin
        fail    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
`ifdef TOUR_TIMEOUT_EN
    if (timeout_hit) state_n = ST_FAIL;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_ff1     <= 1'b0;
      go_ff2     <= 1'b0;
      xx         <= '1;
      yy         <= '1;
      try_mv     <= '0;
      move_count <= '0;
      board      <= '0;
      for (int i = 0; i < NMOVES; i++) begin
        moves_taken[i] <= '0;
        poss_moves[i]  <= '0;
      end
    end else begin
      go_ff1 <= go;
      go_ff2 <= go_ff1;
      case (state)
        ST_IDLE: begin
          if (go_ff2) begin
            board      <= '0;
            move_count <= '0;
          end
        end
        ST_INIT: begin
          if (start_ok) begin
            board[sq(x_start, y_start)] <= 1'b1;
            xx <= x_start;
            yy <= y_start;
          end
        end
        ST_POSS: begin
          poss_moves[mc_idx] <= in_bounds_mask(int'(xx), int'(yy), BOARD_DIM);
          try_mv             <= MV_B0;
        end
        ST_MOVE: begin
          if (cand_legal) begin
            board[sq(gen_x, gen_y)] <= 1'b1;
            moves_taken[mc_idx]     <= try_mv;
            xx                      <= gen_x;
            yy                      <= gen_y;
            move_count              <= move_count + 1'b1;
          end else begin
            try_mv <= try_mv << 1;
          end
        end
        ST_BACKUP: begin
          // The knight returns to a square it came from, so modular
          // subtraction at coordinate width is exact.
          if (move_count != '0) begin
            board[sq(xx, yy)] <= 1'b0;
            xx                <= xx - CW'(off_x(prev_mv));
            yy                <= yy - CW'(off_y(prev_mv));
            move_count        <= move_count - 1'b1;
            try_mv            <= prev_mv << 1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_knight_tour_solver.sv
// tb/tb_knight_tour_solver.sv - directed table-driven bench for knight_tour_solver
// on 5x5, 3x3 and 4x4 boards, plus reset and timeout sequences.
module tb_knight_tour_solver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] x5, y5;
  logic [1:0] x3, y3, x4, y4;
  logic       go5, go3, go4;
  logic       busy5, done5, fail5, busy3, done3, fail3, busy4, done4, fail4;
  logic [4:0] indx5;
  logic [2:0] indx3;
  logic [3:0] indx4;
  logic [7:0] mv5, mv3, mv4;
`ifdef TOUR_TIMEOUT_EN
  logic       to5, to3, to4, to_t;
  logic [2:0] xt, yt;
  logic       go_t, busy_t, done_t, fail_t;
  logic [4:0] indx_t;
  logic [7:0] mv_t;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int cur_sel  = 5;
  logic s_busy, s_done, s_fail;
  int r_done, r_fail, r_busy, r_overlap, r_lat, r_expired;

  always #5 clk = ~clk;

  knight_tour_solver #(.BOARD_DIM(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .x_start(x5), .y_start(y5), .go(go5),
    .busy(busy5), .done(done5), .fail(fail5),
`ifdef TOUR_TIMEOUT_EN
    .timed_out(to5),
`endif
    .indx(indx5), .move(mv5));

  knight_tour_solver #(.BOARD_DIM(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .x_start(x3), .y_start(y3), .go(go3),
    .busy(busy3), .done(done3), .fail(fail3),
`ifdef TOUR_TIMEOUT_EN
    .timed_out(to3),
`endif
    .indx(indx3), .move(mv3));

  knight_tour_solver #(.BOARD_DIM(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .x_start(x4), .y_start(y4), .go(go4),
    .busy(busy4), .done(done4), .fail(fail4),
`ifdef TOUR_TIMEOUT_EN
    .timed_out(to4),
`endif
    .indx(indx4), .move(mv4));

`ifdef TOUR_TIMEOUT_EN
  knight_tour_solver #(.BOARD_DIM(5), .TIMEOUT_CYC(100)) dut_t (
    .clk(clk), .rst_n(rst_n), .x_start(xt), .y_start(yt), .go(go_t),
    .busy(busy_t), .done(done_t), .fail(fail_t), .timed_out(to_t),
    .indx(indx_t), .move(mv_t));
`endif

  always_comb begin
    s_busy = busy5;
    s_done = done5;
    s_fail = fail5;
    case (cur_sel)
      3: begin s_busy = busy3; s_done = done3; s_fail = fail3; end
      4: begin s_busy = busy4; s_done = done4; s_fail = fail4; end
`ifdef TOUR_TIMEOUT_EN
      9: begin s_busy = busy_t; s_done = done_t; s_fail = fail_t; end
`endif
      default: ;
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic set_xy_go(input int sel, input int x, input int y, input logic g);
    case (sel)
      3: begin x3 = 2'(x); y3 = 2'(y); go3 = g; end
      4: begin x4 = 2'(x); y4 = 2'(y); go4 = g; end
`ifdef TOUR_TIMEOUT_EN
      9: begin xt = 3'(x); yt = 3'(y); go_t = g; end
`endif
      default: begin x5 = 3'(x); y5 = 3'(y); go5 = g; end
    endcase
  endtask

  // Pulses go, then watches the selected solver until its first done/fail
  // (bounded by max_cyc) and a few cycles beyond for stray pulses.
  task automatic run_solve(input int sel, input int x, input int y, input int hold, input int max_cyc);
    bit seen;
    seen = 0;
    r_done = 0; r_fail = 0; r_busy = 0; r_overlap = 0; r_lat = 0; r_expired = 0;
    cur_sel = sel;
    @(negedge clk);
    set_xy_go(sel, x, y, 1'b1);
    for (int c = 0; c < max_cyc && !seen; c++) begin
      @(posedge clk);
      #1;
      if (c + 1 >= hold) set_xy_go(sel, x, y, 1'b0);
      if (s_busy) r_busy++;
      if (s_done) r_done++;
      if (s_fail) r_fail++;
      if ((s_busy && (s_done || s_fail)) || (s_done && s_fail)) r_overlap++;
      if (s_done || s_fail) begin
        seen  = 1;
        r_lat = c + 1;
      end
    end
    if (!seen) r_expired = 1;
    set_xy_go(sel, x, y, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (s_done) r_done++;
      if (s_fail) r_fail++;
    end
  endtask

  // Replays the 24 recorded moves on dut5 with the bench's own offset table.
  task automatic check_tour(input int sx, input int sy, input int exp_first, input string tag);
    int dxs[8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
    int dys[8] = '{2, 2, 1, -1, -2, -2, -1, 1};
    bit vis[25];
    int x, y, bad, cnt, k;
    logic [7:0] m, first;
    for (int i = 0; i < 25; i++) vis[i] = 0;
    x = sx; y = sy; bad = 0; cnt = 1; first = 8'h00;
    vis[y*5+x] = 1;
    for (int i = 0; i < 24; i++) begin
      indx5 = 5'(i);
      #1;
      m = mv5;
      if (i == 0) first = m;
      k = -1;
      for (int b = 0; b < 8; b++) if (m == (8'h01 << b)) k = b;
      if (k < 0) begin bad++; break; end
      x += dxs[k];
      y += dys[k];
      if (x < 0 || x > 4 || y < 0 || y > 4) begin bad++; break; end
      if (vis[y*5+x]) bad++;
      else begin vis[y*5+x] = 1; cnt++; end
    end
    check({tag, "_bad_steps"}, bad, 0);
    check({tag, "_squares_visited"}, cnt, 25);
    if (exp_first != 0) check({tag, "_first_move"}, int'(first), exp_first);
  endtask

  typedef struct {
    int sel;
    int x;
    int y;
    int hold;
    int max_cyc;
    bit exp_done;
    int exp_busy;
    int exp_lat;
    int exp_first;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int nz;
    vecs[0] = '{5, 0, 0, 3, 4000000, 1'b1, 0, 0, 8'h02};  // corner tour, first move b1
    vecs[1] = '{3, 1, 1, 1, 20, 1'b0, 11, 14, 0};         // 3x3 centre: all moves off-board
    vecs[2] = '{3, 0, 0, 1, 20000, 1'b0, 0, 0, 0};        // 3x3 corner: exhaustive, no tour
    vecs[3] = '{4, 0, 0, 1, 2000000, 1'b0, 0, 0, 0};      // 4x4: exhaustive, no tour
    vecs[4] = '{5, 5, 2, 1, 10, 1'b0, 1, 4, 0};           // illegal column
    vecs[5] = '{3, 3, 0, 1, 10, 1'b0, 1, 4, 0};           // illegal column, small board

    rst_n = 1'b0;
    x5 = '0; y5 = '0; x3 = '0; y3 = '0; x4 = '0; y4 = '0;
    go5 = 1'b0; go3 = 1'b0; go4 = 1'b0;
    indx5 = '0; indx3 = '0; indx4 = '0;
`ifdef TOUR_TIMEOUT_EN
    xt = '0; yt = '0; go_t = 1'b0; indx_t = '0;
`endif
    repeat (3) @(negedge clk);
    check("reset_flags5", int'({busy5, done5, fail5}), 0);
    check("reset_flags3", int'({busy3, done3, fail3}), 0);
    check("reset_flags4", int'({busy4, done4, fail4}), 0);
    check("reset_move5", int'(mv5), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_solve(vecs[i].sel, vecs[i].x, vecs[i].y, vecs[i].hold, vecs[i].max_cyc);
      check($sformatf("v%0d_bound_expired", i), r_expired, 0);
      check($sformatf("v%0d_done_pulses", i), r_done, vecs[i].exp_done ? 1 : 0);
      check($sformatf("v%0d_fail_pulses", i), r_fail, vecs[i].exp_done ? 0 : 1);
      check($sformatf("v%0d_overlap", i), r_overlap, 0);
      if (vecs[i].exp_busy != 0) check($sformatf("v%0d_busy_cycles", i), r_busy, vecs[i].exp_busy);
      if (vecs[i].exp_lat != 0) check($sformatf("v%0d_latency", i), r_lat, vecs[i].exp_lat);
      if (vecs[i].exp_done && vecs[i].sel == 5)
        check_tour(vecs[i].x, vecs[i].y, vecs[i].exp_first, $sformatf("v%0d", i));
    end

    indx5 = 5'd24; #1 check("indx24_move", int'(mv5), 0);
    indx5 = 5'd31; #1 check("indx31_move", int'(mv5), 0);
    indx4 = 4'd15; #1 check("indx15_move4", int'(mv4), 0);

    // Mid-solve reset from the centre, then a clean re-run.
    cur_sel = 5;
    @(negedge clk);
    x5 = 3'd2; y5 = 3'd2; go5 = 1'b1;
    repeat (40) @(negedge clk);
    go5 = 1'b0;
    check("mid_solve_busy", int'(busy5), 1);
    rst_n = 1'b0;
    #1 check("async_reset_flags", int'({busy5, done5, fail5}), 0);
    repeat (2) @(negedge clk);
    nz = 0;
    for (int i = 0; i < 32; i++) begin
      indx5 = 5'(i);
      #1;
      if (mv5 != 8'h00) nz++;
    end
    check("reset_moves_nonzero", nz, 0);
    check("reset_held_flags", int'({busy5, done5, fail5}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_solve(5, 2, 2, 1, 4000000);
    check("rerun_bound_expired", r_expired, 0);
    check("rerun_done_pulses", r_done, 1);
    check("rerun_fail_pulses", r_fail, 0);
    check("rerun_overlap", r_overlap, 0);
    check_tour(2, 2, 0, "rerun");
    indx5 = 5'd24; #1 check("rerun_indx24_move", int'(mv5), 0);

`ifdef TOUR_TIMEOUT_EN
    run_solve(9, 1, 0, 1, 300);
    check("timeout_bound_expired", r_expired, 0);
    check("timeout_fail_pulses", r_fail, 1);
    check("timeout_done_pulses", r_done, 0);
    check("timeout_busy_cycles", r_busy, 100);
    check("timeout_sticky", int'(to_t), 1);
    @(negedge clk);
    xt = 3'd0; yt = 3'd0; go_t = 1'b1;
    repeat (4) @(negedge clk);
    go_t = 1'b0;
    check("timeout_cleared_on_go", int'(to_t), 0);
    repeat (120) @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
